// File: rtl/button_pkg.sv
// Shared definitions for the push-button UI blocks: FSM state encoding,
// default timing constants and a width helper for prescalers.
package button_pkg;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PRESS = 2'd2,
    ST_LONG  = 2'd3
  } btn_state_e;

  // 1 ms tick from a 12 MHz system clock
  localparam int unsigned DEF_TICK_DIV = 32'd12000;
  localparam int unsigned DEF_CNT_W    = 32'd16;

  // Bits needed to hold 0..n-1, never less than one
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n > 32'd1) begin
      cnt_width = $clog2(n);
    end else begin
      cnt_width = 32'd1;
    end
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks.
// A synchronous clear restarts the period so downstream thresholds are exact.
module tick_gen
  import button_pkg::*;
#(
  parameter int unsigned DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned     W    = cnt_width(DIV);
  localparam logic [W-1:0]    LAST = W'(DIV - 32'd1);
  localparam logic [W-1:0]    ONE  = W'(1);

  logic [W-1:0] cnt_r;

  // Prescale counter: wraps at DIV-1, restarts on clear
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/button_event_fsm.sv
// Converts a debounced button level into registered single-cycle events:
// short press, long press, auto-repeat and release, plus a held level.
module button_event_fsm
  import button_pkg::*;
#(
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned LONG_TICKS   = 32'd800,
  parameter int unsigned REPEAT_TICKS = 32'd200,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic n_reset,
  input  logic db_in,
  input  logic enable,
  output logic held,
  output logic short_press,
  output logic long_press,
  output logic repeat_evt,
  output logic release_evt
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 32'd1);
  localparam logic [CNT_W-1:0] REP_LAST  =
    (REPEAT_TICKS == 32'd0) ? '0 : CNT_W'(REPEAT_TICKS - 32'd1);
  localparam bit               REP_EN    = (REPEAT_TICKS != 32'd0);

  btn_state_e       state_r, state_nxt;
  logic             db_q_r;
  logic [CNT_W-1:0] tick_cnt_r, tick_cnt_nxt;
  logic [CNT_W-1:0] rep_cnt_r, rep_cnt_nxt;
  logic             held_r, short_r, long_r, rep_r, rel_r;
  logic             held_nxt, short_nxt, long_nxt, rep_nxt, rel_nxt;
  logic             pressed_s, tick_s, tick_clr_s;

  assign pressed_s = db_q_r ^ ACTIVE_LOW;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (tick_clr_s),
    .tick    (tick_s)
  );

  // Next-state, counter and event decode; release beats a coincident tick
  always_comb begin
    state_nxt    = state_r;
    tick_cnt_nxt = tick_cnt_r;
    rep_cnt_nxt  = rep_cnt_r;
    tick_clr_s   = 1'b0;
    short_nxt    = 1'b0;
    long_nxt     = 1'b0;
    rep_nxt      = 1'b0;
    rel_nxt      = 1'b0;
    case (state_r)
      ST_ARM: begin
        tick_cnt_nxt = '0;
        rep_cnt_nxt  = '0;
        if (!enable) begin
          state_nxt = ST_ARM;
        end else if (!pressed_s && tick_s) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_ARM;
        end
      end
      ST_IDLE: begin
        if (!enable) begin
          state_nxt = ST_ARM;
        end else if (pressed_s) begin
          state_nxt    = ST_PRESS;
          tick_cnt_nxt = '0;
          tick_clr_s   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (!enable) begin
          state_nxt = ST_ARM;
        end else if (!pressed_s) begin
          state_nxt = ST_IDLE;
          short_nxt = 1'b1;
          rel_nxt   = 1'b1;
        end else if (tick_s && (tick_cnt_r == LONG_LAST)) begin
          state_nxt   = ST_LONG;
          long_nxt    = 1'b1;
          rep_cnt_nxt = '0;
        end else if (tick_s) begin
          tick_cnt_nxt = tick_cnt_r + CNT_ONE;
        end else begin
          tick_cnt_nxt = tick_cnt_r;
        end
      end
      ST_LONG: begin
        if (!enable) begin
          state_nxt = ST_ARM;
        end else if (!pressed_s) begin
          state_nxt = ST_IDLE;
          rel_nxt   = 1'b1;
        end else if (tick_s && REP_EN) begin
          // rep_cnt restarts on every repeat, so it never wraps
          if (rep_cnt_r == REP_LAST) begin
            rep_nxt     = 1'b1;
            rep_cnt_nxt = '0;
          end else begin
            rep_cnt_nxt = rep_cnt_r + CNT_ONE;
          end
        end else begin
          rep_cnt_nxt = rep_cnt_r;
        end
      end
      default: begin
        state_nxt = ST_ARM;
      end
    endcase
    held_nxt = (state_nxt == ST_PRESS) || (state_nxt == ST_LONG);
  end

  // State, input sample, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_r    <= ST_ARM;
      db_q_r     <= ACTIVE_LOW;
      tick_cnt_r <= '0;
      rep_cnt_r  <= '0;
      held_r     <= 1'b0;
      short_r    <= 1'b0;
      long_r     <= 1'b0;
      rep_r      <= 1'b0;
      rel_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      db_q_r     <= db_in;
      tick_cnt_r <= tick_cnt_nxt;
      rep_cnt_r  <= rep_cnt_nxt;
      held_r     <= held_nxt;
      short_r    <= short_nxt;
      long_r     <= long_nxt;
      rep_r      <= rep_nxt;
      rel_r      <= rel_nxt;
    end
  end

  assign held        = held_r;
  assign short_press = short_r;
  assign long_press  = long_r;
  assign repeat_evt  = rep_r;
  assign release_evt = rel_r;

endmodule
